// File: rtl/ysyx_22050854_mul_ctrl_if.sv
// Purpose : groups the EXU request/response handshake and the multiplier
//           issue/result bus of ysyx_22050854_mul_ctrl into one bundle.
// Ports   : req_* / resp_* / busy face the EXU; m_* face the 4-stage multiplier.
//           modport master = controller view, modport slave = EXU + multiplier view.
interface ysyx_22050854_mul_ctrl_if #(
  parameter int TAG_W = 5
);
  // EXU side
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [63:0]      req_src1;
  logic [63:0]      req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  // multiplier side
  logic             m_valid;
  logic             m_mulw;
  logic [1:0]       m_signed;
  logic [63:0]      m_src1;
  logic [63:0]      m_src2;
  logic             m_flush;
  logic             m_ready;
  logic             m_out_valid;
  logic [63:0]      m_hi;
  logic [63:0]      m_lo;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, req_tag, resp_ready,
           m_ready, m_out_valid, m_hi, m_lo,
    output req_ready, resp_valid, resp_data, resp_tag, busy,
           m_valid, m_mulw, m_signed, m_src1, m_src2, m_flush
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, req_tag, resp_ready,
           m_ready, m_out_valid, m_hi, m_lo,
    input  req_ready, resp_valid, resp_data, resp_tag, busy,
           m_valid, m_mulw, m_signed, m_src1, m_src2, m_flush
  );
endinterface

// File: rtl/ysyx_22050854_mul_ctrl.sv
// Purpose : issues one RV64 M-extension multiply at a time to the Booth/Wallace
//           multiplier, decodes op into mulw/mul_signed, selects hi/lo result.
// Latency : accept T -> m_valid T+1 -> resp_valid T+6 (plus m_ready stall cycles);
//           with YSYX_22050854_MUL_REUSE_EN defined a cache hit responds at T+1.
// Backpr. : response held stable in DONE until resp_ready; req_ready only in IDLE.
// Ports   : clk, rst (sync active-low), flush (plain); bus = ysyx_22050854_mul_ctrl_if.master.
module ysyx_22050854_mul_ctrl #(
  parameter int TAG_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  ysyx_22050854_mul_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_m_valid;
  logic             r_m_mulw;
  logic [1:0]       r_m_signed;
  logic [63:0]      r_src1;
  logic [63:0]      r_src2;
  logic [63:0]      r_resp_data;
  logic [TAG_W-1:0] r_tag;

  logic             w_req_ready;
  logic             w_accept;
  logic [2:0]       w_op;
  logic [1:0]       w_signed;
  logic             w_mulw;
  logic             w_cap;
  logic             w_hit;
  logic [63:0]      w_hit_data;

  function automatic logic [63:0] sel_result(input logic [2:0] op,
                                             input logic [63:0] hi,
                                             input logic [63:0] lo);
    case (op)
      3'd0:    sel_result = lo;
      3'd4:    sel_result = {{32{lo[31]}}, lo[31:0]};
      default: sel_result = hi;
    endcase
  endfunction

  // Illegal encodings are folded into MUL at decode so everything downstream
  // only ever sees the five legal ops.
  assign w_op     = (bus.req_op > 3'd4) ? 3'd0 : bus.req_op;
  assign w_signed = (w_op == 3'd3) ? 2'b00 : (w_op == 3'd2) ? 2'b10 : 2'b11;
  assign w_mulw   = (w_op == 3'd4);

  assign w_req_ready = (r_state == S_IDLE) & ~flush & rst;
  assign w_accept    = bus.req_valid & w_req_ready;
  // Result captured only on a genuine (non-flushed) completion in WAIT.
  assign w_cap       = (r_state == S_WAIT) & ~flush & bus.m_out_valid;

`ifdef YSYX_22050854_MUL_REUSE_EN
  logic        r_c_vld;
  logic [63:0] r_c_src1;
  logic [63:0] r_c_src2;
  logic [63:0] r_c_hi;
  logic [63:0] r_c_lo;
  logic [1:0]  r_c_signed;
  logic        r_c_mulw;

  // Only the valid bit needs reset; the payload is qualified by it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_c_vld <= 1'b0;
    end else if (w_cap) begin
      r_c_vld    <= 1'b1;
      r_c_src1   <= r_src1;
      r_c_src2   <= r_src2;
      r_c_signed <= r_m_signed;
      r_c_mulw   <= r_m_mulw;
      r_c_hi     <= bus.m_hi;
      r_c_lo     <= bus.m_lo;
    end
  end

  assign w_hit      = r_c_vld & (r_c_src1 == bus.req_src1) & (r_c_src2 == bus.req_src2) &
                      (r_c_signed == w_signed) & (r_c_mulw == w_mulw);
  assign w_hit_data = sel_result(w_op, r_c_hi, r_c_lo);
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 64'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_m_valid   <= 1'b0;
      r_m_mulw    <= 1'b0;
      r_m_signed  <= 2'b00;
      r_src1      <= 64'd0;
      r_src2      <= 64'd0;
      r_resp_data <= 64'd0;
      r_tag       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= w_op;
            r_src1     <= bus.req_src1;
            r_src2     <= bus.req_src2;
            r_tag      <= bus.req_tag;
            r_m_signed <= w_signed;
            r_m_mulw   <= w_mulw;
            if (w_hit) begin
              r_state     <= S_DONE;
              r_resp_data <= w_hit_data;
            end else begin
              r_state   <= S_ISSUE;
              r_m_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (flush) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
          end else if (bus.m_ready) begin
            r_state   <= S_WAIT;
            r_m_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (flush) begin
            // A result landing in the flush cycle itself is already drained.
            r_state <= bus.m_out_valid ? S_IDLE : S_DRAIN;
          end else if (bus.m_out_valid) begin
            r_state     <= S_DONE;
            r_resp_data <= sel_result(r_op, bus.m_hi, bus.m_lo);
          end
        end
        S_DONE: begin
          if (flush || bus.resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus.m_out_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  // Flush masks the handshakes combinationally so nothing issues or transfers
  // in the flush cycle.
  assign bus.m_valid    = r_m_valid & ~flush;
  assign bus.resp_valid = (r_state == S_DONE) & ~flush;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_tag   = r_tag;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.m_mulw     = r_m_mulw;
  assign bus.m_signed   = r_m_signed;
  assign bus.m_src1     = r_src1;
  assign bus.m_src2     = r_src2;
  assign bus.m_flush    = flush;

endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
module tb_ysyx_22050854_mul_ctrl;

  logic clk;
  logic rst;
  logic flush;

  ysyx_22050854_mul_ctrl_if #(.TAG_W(5)) bus ();

  ysyx_22050854_mul_ctrl #(.TAG_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-stage multiplier model (ignores flush and rst) -------
  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] s, input logic w);
    logic [63:0]  x;
    logic [63:0]  y;
    logic [127:0] ax;
    logic [127:0] by;
    x  = w ? {{32{a[31]}}, a[31:0]} : a;
    y  = w ? {{32{b[31]}}, b[31:0]} : b;
    ax = {{64{s[1] & x[63]}}, x};
    by = {{64{s[0] & y[63]}}, y};
    prod = ax * by;
  endfunction

  logic [3:0]   r_pv = 4'd0;
  logic [63:0]  r_phi [4];
  logic [63:0]  r_plo [4];
  logic [127:0] w_p;

  assign w_p = prod(bus.m_src1, bus.m_src2, bus.m_signed, bus.m_mulw);

  always @(posedge clk) begin
    r_pv     <= {r_pv[2:0], bus.m_valid & bus.m_ready};
    r_phi[0] <= w_p[127:64];
    r_plo[0] <= w_p[63:0];
    for (int i = 1; i < 4; i++) begin
      r_phi[i] <= r_phi[i-1];
      r_plo[i] <= r_plo[i-1];
    end
  end

  assign bus.m_out_valid = r_pv[3];
  assign bus.m_hi        = r_phi[3];
  assign bus.m_lo        = r_plo[3];

  // ---------------- event monitors ----------------------------------------
  int n_issue = 0;
  int n_rv    = 0;
  int n_xfer  = 0;
  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready)     n_issue++;
    if (bus.resp_valid)                 n_rv++;
    if (bus.resp_valid && bus.resp_ready) n_xfer++;
  end

  // ---------------- checking ----------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"},  {63'd0, bus.req_ready},  64'd0);
    chk({pfx, "_resp_valid"}, {63'd0, bus.resp_valid}, 64'd0);
    chk({pfx, "_resp_data"},  bus.resp_data,           64'd0);
    chk({pfx, "_resp_tag"},   {59'd0, bus.resp_tag},   64'd0);
    chk({pfx, "_busy"},       {63'd0, bus.busy},       64'd0);
    chk({pfx, "_m_valid"},    {63'd0, bus.m_valid},    64'd0);
    chk({pfx, "_m_mulw"},     {63'd0, bus.m_mulw},     64'd0);
    chk({pfx, "_m_signed"},   {62'd0, bus.m_signed},   64'd0);
    chk({pfx, "_m_src1"},     bus.m_src1,              64'd0);
    chk({pfx, "_m_src2"},     bus.m_src2,              64'd0);
  endtask

  // Called at a negedge with the controller idle; returns at posedge+1.
  task automatic accept_req(input string name, input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] tag);
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    chk({name, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic txn(input string name, input logic [2:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] tag, input logic [63:0] edata,
                     input logic [1:0] es, input logic ew, input int elat,
                     input int stall, input int hold);
    exp_t        e;
    int          k;
    int          i0;
    int          x0;
    logic [63:0] d0;
    logic [4:0]  t0;
    e.data = edata;
    e.tag  = tag;
    sb.push_back(e);
    i0 = n_issue;
    x0 = n_xfer;
    bus.resp_ready = (hold == 0);
    accept_req(name, op, a, b, tag);
    bus.m_ready = (stall == 0);
    @(negedge clk);
    k = 1;
    chk({name, "_m_valid_t1"}, {63'd0, bus.m_valid}, {63'd0, (elat > 1)});
    chk({name, "_m_signed"}, {62'd0, bus.m_signed}, {62'd0, es});
    chk({name, "_m_mulw"}, {63'd0, bus.m_mulw}, {63'd0, ew});
    chk({name, "_m_src1"}, bus.m_src1, a);
    chk({name, "_m_src2"}, bus.m_src2, b);
    while (!bus.resp_valid && k < 60) begin
      if (k > stall) bus.m_ready = 1'b1;
      @(negedge clk);
      k++;
    end
    bus.m_ready = 1'b1;
    chk({name, "_latency"}, 64'(k), 64'(elat));
    e  = sb.pop_front();
    chk({name, "_resp_data"}, bus.resp_data, e.data);
    chk({name, "_resp_tag"}, {59'd0, bus.resp_tag}, {59'd0, e.tag});
    d0 = bus.resp_data;
    t0 = bus.resp_tag;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, {63'd0, bus.resp_valid}, 64'd1);
      chk({name, "_hold_data"}, bus.resp_data, d0);
      chk({name, "_hold_tag"}, {59'd0, bus.resp_tag}, {59'd0, t0});
      chk({name, "_hold_req_ready"}, {63'd0, bus.req_ready}, 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
    chk({name, "_resp_valid_after"}, {63'd0, bus.resp_valid}, 64'd0);
    chk({name, "_xfers"}, 64'(n_xfer - x0), 64'd1);
    chk({name, "_issues"}, 64'(n_issue - i0), {63'd0, (elat > 1)});
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RA   = 64'h0000_0001_0000_0003;
  localparam logic [63:0] RB   = 64'h0000_0001_0000_0005;

  initial begin : main
    int i0;
    int r0;
    rst            = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_src1   = 64'd0;
    bus.req_src2   = 64'd0;
    bus.req_tag    = 5'd0;
    bus.resp_ready = 1'b1;
    bus.m_ready    = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // name, op, src1, src2, tag, expected data, m_signed, m_mulw, latency, stall, hold
    txn("mul",    3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 2'b11, 1'b0, 6, 0, 0);
    txn("mulhu",  3'd3, ONES, ONES, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0, 6, 0, 3);
    txn("mulh",   3'd1, ONES, ONES, 5'd3, 64'd0, 2'b11, 1'b0, 6, 0, 0);
    txn("mulw",   3'd4, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 1'b1, 6, 0, 0);
    txn("mulhsu", 3'd2, ONES, 64'd2, 5'd5, ONES, 2'b10, 1'b0, 8, 2, 0);
    txn("illegal",3'd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd6, 64'hFFFF_FFFF_FFFF_FFF1, 2'b11, 1'b0, 6, 0, 0);

    // Flush while WAITing: drained, no response, req_ready back after m_out_valid.
    i0 = n_issue;
    r0 = n_rv;
    accept_req("fl_wait", 3'd0, 64'd7, 64'd9, 5'd9);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_wait_rdy_t4", {63'd0, bus.req_ready}, 64'd0);
    chk("fl_wait_busy_t4", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    chk("fl_wait_rdy_t5", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    chk("fl_wait_rdy_t6", {63'd0, bus.req_ready}, 64'd1);
    chk("fl_wait_busy_t6", {63'd0, bus.busy}, 64'd0);
    chk("fl_wait_no_resp", 64'(n_rv - r0), 64'd0);
    chk("fl_wait_issues", 64'(n_issue - i0), 64'd1);

    // Flush in ISSUE: no m_valid pulse, straight back to IDLE.
    i0 = n_issue;
    r0 = n_rv;
    accept_req("fl_issue", 3'd0, 64'd7, 64'd9, 5'd10);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_issue_m_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("fl_issue_req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("fl_issue_m_flush", {63'd0, bus.m_flush}, 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_issue_busy", {63'd0, bus.busy}, 64'd0);
    chk("fl_issue_rdy", {63'd0, bus.req_ready}, 64'd1);
    repeat (6) @(negedge clk);
    chk("fl_issue_no_issue", 64'(n_issue - i0), 64'd0);
    chk("fl_issue_no_resp", 64'(n_rv - r0), 64'd0);

    // Reset in T+2 with a product in flight.
    r0 = n_rv;
    accept_req("rst_mid", 3'd0, 64'd11, 64'd13, 5'd11);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_resp", 64'(n_rv - r0), 64'd0);
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mid_rdy", {63'd0, bus.req_ready}, 64'd1);

    // MULH then MUL of the same operands; hits the reuse cache when enabled.
    txn("pair_mulh", 3'd1, RA, RB, 5'd12, 64'd1, 2'b11, 1'b0, 6, 0, 0);
`ifdef YSYX_22050854_MUL_REUSE_EN
    txn("pair_mul", 3'd0, RA, RB, 5'd13, 64'h0000_0008_0000_000F, 2'b11, 1'b0, 1, 0, 0);
`else
    txn("pair_mul", 3'd0, RA, RB, 5'd13, 64'h0000_0008_0000_000F, 2'b11, 1'b0, 6, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_mul_ctrl.md
# ysyx_22050854_mul_ctrl

Issue/response controller between the EXU and the 4-stage Booth/Wallace multiplier. It decodes RISC-V M-extension multiply ops into the multiplier's `mulw`/`mul_signed` controls and registers the operands. It sequences one multiplication at a time, captures the one-cycle `out_valid` result and selects `result_hi` or `result_lo`. It holds the response under back-pressure and handles pipeline flush, including draining a multiplication that is already in flight.

## Interface

Parameters:
- `TAG_W`, 5: width of the destination tag carried with each request.

Ports (reset is synchronous and active-low; the clock and reset ports are named `clk` and `rst`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-low reset.
- `flush` in 1: cancel the current operation; also forwarded to the multiplier's `flush`.
- `req_valid` in 1: EXU request valid.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; 101–111 are illegal.
- `req_src1` in 64: rs1, drives `multiplicand`.
- `req_src2` in 64: rs2, drives `multiplier`.
- `req_tag` in TAG_W: destination tag.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 64: final rd value.
- `resp_tag` out TAG_W: tag of the response.
- `busy` out 1: state ≠ IDLE.
- `m_valid` out 1: to the multiplier's `mul_valid`.
- `m_mulw` out 1: to `mulw`.
- `m_signed` out 2: to `mul_signed`.
- `m_src1` out 64: to `multiplicand`.
- `m_src2` out 64: to `multiplier`.
- `m_flush` out 1: to `flush`.
- `m_ready` in 1: from the multiplier's `mul_ready`.
- `m_out_valid` in 1: from `out_valid`; high for one cycle.
- `m_hi` in 64: from `result_hi`.
- `m_lo` in 64: from `result_lo`.

## Operation

States are IDLE, ISSUE, WAIT, DONE and DRAIN.

- **req_ready:** `req_ready = (state==IDLE) & ~flush & rst`.
  - A request is accepted on `req_valid & req_ready`.
  - On acceptance the controller registers op, srcs and tag, and goes to ISSUE.
  - An illegal op is accepted and completes as MUL.
- **Op decode:**
  - MUL, MULH and MULW map to `m_signed`=11.
  - MULHSU maps to 10.
  - MULHU maps to 00.
  - `m_mulw`=1 only for MULW.
- **ISSUE:**
  - `m_valid` is high with the registered operands.
  - The state moves to WAIT on `m_valid & m_ready`; otherwise it stays in ISSUE.
- **WAIT:** on `m_out_valid` the controller captures `resp_data` and moves to DONE. Result selection:
  - MUL: `m_lo`.
  - MULH, MULHSU, MULHU: `m_hi`.
  - MULW: `{{32{m_lo[31]}}, m_lo[31:0]}`.
- **DONE:**
  - `resp_valid` is high.
  - `resp_data` and `resp_tag` stay stable until `resp_valid & resp_ready`, then the state returns to IDLE.
  - Back-to-back issue needs one IDLE cycle in between.
- **Flush, by state:**
  - IDLE: no effect.
  - ISSUE: return to IDLE. `m_valid` is forced low in the flush cycle, so nothing is issued.
  - WAIT: go to DRAIN. DRAIN waits for `m_out_valid`, discards the result, and returns to IDLE. `resp_valid` stays 0 throughout.
  - DONE: drop the response and return to IDLE.
  - Flush takes priority over `resp_ready` and over request acceptance in the same cycle.
- **m_flush:** equals `flush`. The controller does not rely on the multiplier honouring it.
- **m_out_valid outside WAIT/DRAIN:** ignored.
- **Reset (rst=0) at any point:** state returns to IDLE. A result still in flight from the multiplier arrives in IDLE and is ignored.

## Timing

- Reset values are 0 for all of: `req_ready`, `resp_valid`, `resp_data`, `resp_tag`, `busy`, `m_valid`, `m_mulw`, `m_signed`, `m_src1`, `m_src2`.
- Request accepted in cycle T:
  - `m_valid` is high in T+1.
  - With `m_ready` high in T+1, the multiplier raises `m_out_valid` in T+5.
  - `resp_valid` rises in T+6.
- Each cycle that `m_ready` is low in ISSUE adds one cycle to the latency.
- The controller makes no fixed-latency assumption; WAIT lasts until `m_out_valid` with no timeout.
- The reuse-cache hit path is described under Configuration.

## Configuration

- `YSYX_22050854_MUL_REUSE_EN`
  - **Defined:** a one-entry cache holds `{src1, src2, m_signed, m_mulw, m_hi, m_lo, valid}` from the last completed (non-drained) multiplication.
    - A request whose operands, sign mode and mulw match a valid entry goes IDLE→DONE directly.
    - On a hit, `resp_valid` is high in T+1 with the result selected from the cached hi/lo, and no `m_valid` pulse occurs.
    - This covers the MULH followed by MUL fusion pair.
    - The entry is cleared by reset only. Flush does not clear it, and drained results are never written.
  - **Undefined:** no cache exists; every request goes through ISSUE and WAIT.

## Test plan

- **MUL:** MUL src1=3, src2=0xFFFF_FFFF_FFFF_FFFB, `resp_ready`=1 → `m_signed`=11, `m_mulw`=0; `resp_data`=0xFFFF_FFFF_FFFF_FFF1 at T+6; `busy` low at T+7.
- **MULHU and MULH:** MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → `m_signed`=00, `resp_data`=0xFFFF_FFFF_FFFF_FFFE. MULH of the same operands → 0.
- **MULW:** MULW 0x7FFF_FFFF × 2 → `m_mulw`=1, `resp_data`=0xFFFF_FFFF_FFFF_FFFE.
- **Back-pressure:** `resp_ready` held low for 3 cycles after `resp_valid` → `resp_data` and `resp_tag` unchanged; `req_ready` low; one transfer on release.
- **Flush:**
  - Flush at T+3 (WAIT) → no `resp_valid`, `req_ready` low until the cycle after `m_out_valid`.
  - Flush at T+1 (ISSUE) → no `m_valid` pulse.
  - Reset low at T+2 → all outputs 0 on the next cycle, and the later `m_out_valid` is ignored.
- **Reuse (macro defined):** MULH a,b then MUL a,b → the second `resp_valid` arrives 1 cycle after acceptance with no `m_valid` pulse, and its data is the low half of the same product.
